line_dda_sequencer: RTL and testbench

Sequencer for the scan-conversion datapath. It accepts a line segment (x0,y0)->(x1,y1) and emits the rasterised pixel stream to the framebuffer writer over a valid/ready handshake. It uses a power-of-two DDA:
- Slope increments are produced by a single shared 12-bit signed right shifter.
- The shifter is time-multiplexed between the X and Y deltas.
- The step count is 2^n, where n is found by a sequential normalisation loop.

---
 rtl/line_dda_sequencer_pkg.sv | 34 +++
 rtl/line_dda_sequencer_ars_trunc_12.sv | 22 ++
 rtl/line_dda_sequencer.sv | 177 +++++++++++++++++
 tb/tb_line_dda_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_dda_sequencer_pkg.sv
// Shared types and constants for the power-of-two DDA line sequencer.
// Widths, FSM state encoding, rounding constant and small arithmetic helpers.
package line_dda_sequencer_pkg;

  localparam int CW = 7;
  localparam int FW = 4;
  localparam int SW = CW + 1 + FW;

  // Shift amount must reach CW; padded to a 4-bit field for the shifter port.
  localparam int SHW = ($clog2(CW + 1) < 4) ? 4 : $clog2(CW + 1);

  localparam logic [SW-1:0] RND = SW'(2 ** (FW - 1));

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_NORM  = 3'd2,
    ST_SHX   = 3'd3,
    ST_SHY   = 3'd4,
    ST_PLOT  = 3'd5,
    ST_STEP  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Round-half-up of a fixed-point accumulator to an integer pixel coordinate.
  function automatic logic [CW-1:0] round_pix(input logic [SW-1:0] acc);
    return CW'((acc + RND) >> FW);
  endfunction

  function automatic logic [CW:0] abs_delta(input logic [CW:0] d);
    return d[CW] ? (~d + 1'b1) : d;
  endfunction

endpackage

// File: rtl/line_dda_sequencer_ars_trunc_12.sv
// Signed right shift that truncates toward zero: shift the magnitude,
// then restore the sign, so negative slopes are never rounded away from zero.
module ars_trunc_12
  import line_dda_sequencer_pkg::*;
(
  input  logic [SW-1:0]  a_i,
  input  logic [SHW-1:0] sh_i,
  output logic [SW-1:0]  y_o
);

  logic          neg;
  logic [SW-1:0] mag;
  logic [SW-1:0] mag_sh;

  always_comb begin
    neg    = a_i[SW-1];
    mag    = neg ? (~a_i + 1'b1) : a_i;
    mag_sh = mag >> sh_i;
    y_o    = neg ? (~mag_sh + 1'b1) : mag_sh;
  end

endmodule

// File: rtl/line_dda_sequencer.sv
// Power-of-two DDA line rasteriser: normalises the major delta to 2^n steps,
// derives both slope increments through one shared shifter, then streams pixels.
module line_dda_sequencer
  import line_dda_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  output logic          busy,
  output logic          done,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [2:0]    dbg_state
);

  state_e         state_q, state_d;
  logic [CW-1:0]  x0_q, y0_q, x1_q, y1_q;
  logic [CW-1:0]  x0_d, y0_d, x1_d, y1_d;
  logic [CW:0]    dx_q, dy_q, dx_d, dy_d;
  logic [CW:0]    m_q, m_d;
  logic [SHW-1:0] n_q, n_d;
  logic           single_q, single_d;
  logic [SW-1:0]  acc_x_q, acc_y_q, acc_x_d, acc_y_d;
  logic [SW-1:0]  inc_x_q, inc_y_q, inc_x_d, inc_y_d;
  logic [CW:0]    k_q, k_d;

  logic [CW:0]    dx_new, dy_new, adx, ady, pow2;
  logic           is_last;
  logic [SW-1:0]  sh_in, sh_out;

  assign dx_new  = {1'b0, x1_q} - {1'b0, x0_q};
  assign dy_new  = {1'b0, y1_q} - {1'b0, y0_q};
  assign adx     = abs_delta(dx_new);
  assign ady     = abs_delta(dy_new);
  assign pow2    = (CW + 1)'(1) << n_q;
  assign is_last = single_q || (k_q == pow2);

  // The one shifter sees dx during SHX and dy during SHY.
  assign sh_in = (state_q == ST_SHY) ? {dy_q, {FW{1'b0}}} : {dx_q, {FW{1'b0}}};

  ars_trunc_12 u_shift (
    .a_i  (sh_in),
    .sh_i (n_q),
    .y_o  (sh_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      m_q      <= '0;
      n_q      <= '0;
      single_q <= 1'b0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      inc_x_q  <= '0;
      inc_y_q  <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      m_q      <= m_d;
      n_q      <= n_d;
      single_q <= single_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      inc_x_q  <= inc_x_d;
      inc_y_q  <= inc_y_d;
      k_q      <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    m_d      = m_q;
    n_d      = n_q;
    single_d = single_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    inc_x_d  = inc_x_q;
    inc_y_d  = inc_y_q;
    k_d      = k_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        dx_d     = dx_new;
        dy_d     = dy_new;
        m_d      = (adx > ady) ? adx : ady;
        n_d      = '0;
        single_d = 1'b0;
        k_d      = '0;
        acc_x_d  = {1'b0, x0_q, {FW{1'b0}}};
        acc_y_d  = {1'b0, y0_q, {FW{1'b0}}};
        state_d  = ST_NORM;
      end
      ST_NORM: begin
        if (pow2 >= m_q) begin
          single_d = (m_q == '0);
          state_d  = ST_SHX;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      ST_SHX: begin
        inc_x_d = sh_out;
        state_d = ST_SHY;
      end
      ST_SHY: begin
        inc_y_d = sh_out;
        state_d = ST_PLOT;
      end
      ST_PLOT: begin
        // Final handshake goes straight to DONE so done follows it by one cycle.
        if (pix_ready) state_d = is_last ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        acc_x_d = acc_x_q + inc_x_q;
        acc_y_d = acc_y_q + inc_y_q;
        k_d     = k_q + 1'b1;
        state_d = ST_PLOT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Valid/ready: while pix_valid is high, pix_x/pix_y hold until pix_ready is seen
  // at a rising edge; that edge is the handshake.
  always_comb begin
    busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done      = (state_q == ST_DONE);
    pix_valid = (state_q == ST_PLOT);
    pix_x     = '0;
    pix_y     = '0;
    if (state_q == ST_PLOT) begin
      pix_x = is_last ? x1_q : round_pix(acc_x_q);
      pix_y = is_last ? y1_q : round_pix(acc_y_q);
    end
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_line_dda_sequencer.sv
// Directed bench for line_dda_sequencer: arithmetic line model, per-cycle
// pixel scoreboard, latency/handshake/done checks and a final report.
module tb_line_dda_sequencer;

  localparam int CW = 7;
  localparam int W  = 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          pix_ready = 1'b1;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic          busy, done, pix_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic [2:0]    dbg_state;

  int            total = 0;
  int            bad = 0;
  int            hs_cnt = 0;
  logic          hs_prev = 1'b0;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  head;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  lit42[5];
  int            n_model;

  always #5 clk = ~clk;

  line_dda_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line model: pixel k sits at round(start + k*slope), slope truncated toward zero.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            output int n);
    int dx, dy, m, am, ix, iy, steps, px, py;
    dx = ax1 - ax0;
    dy = ay1 - ay0;
    m  = (dx < 0) ? -dx : dx;
    am = (dy < 0) ? -dy : dy;
    if (am > m) m = am;
    n = 0;
    while ((1 << n) < m) n++;
    steps = (m == 0) ? 0 : (1 << n);
    ix = (dx * 16) / (1 << n);
    iy = (dy * 16) / (1 << n);
    for (int k = 0; k <= steps; k++) begin
      if (k == steps) begin
        px = ax1;
        py = ay1;
      end else begin
        px = (ax0 * 16 + k * ix + 8) / 16;
        py = (ay0 * 16 + k * iy + 8) / 16;
      end
      exp_q.push_back({px[CW-1:0], py[CW-1:0]});
    end
  endtask

  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int exp_lat);
    int lat;
    @(posedge clk); #1;
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    start = 1'b1;
    hs_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (pix_valid) begin
        lat = c;
        break;
      end
    end
    chk("first_valid_latency", lat, exp_lat);
  endtask

  task automatic finish_line(input int stall_at, input int poke_at, input int exp_count);
    int stall_left;
    bit stalled, got;
    stall_left = 0;
    stalled = 0;
    got = 0;
    for (int c = 0; c < 700; c++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (c == poke_at) begin
        start = 1'b1;
        x0 = CW'($urandom_range(0, 127)); y0 = CW'($urandom_range(0, 127));
        x1 = CW'($urandom_range(0, 127)); y1 = CW'($urandom_range(0, 127));
      end else begin
        start = 1'b0;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) pix_ready = 1'b1;
      end else if (stall_at >= 0 && !stalled && pix_valid && hs_cnt >= stall_at) begin
        pix_ready = 1'b0;
        stalled = 1;
        stall_left = 5;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    chk("done_seen", got, 1);
    chk("pixel_count", hs_cnt, exp_count);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_state", dbg_state, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Per-cycle scoreboard: every shown pixel must equal the model head.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_prev = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("hold_valid", pix_valid, 1);
      if (hs_prev) chk("step_gap", pix_valid, 0);
      if (done) begin
        chk("done_after_handshake", hs_prev, 1);
        chk("done_busy_low", busy, 0);
        chk("done_queue_empty", exp_q.size(), 0);
      end
      if (pix_valid) begin
        chk("pix_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          head = exp_q[0];
          chk("pix_x", pix_x, head[W-1:CW]);
          chk("pix_y", pix_y, head[CW-1:0]);
          if (pix_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      hs_prev = pix_valid && pix_ready;
      stall_prev = pix_valid && !pix_ready;
    end
  end

  initial begin
    int act;
    lit42 = '{{7'd0, 7'd0}, {7'd1, 7'd1}, {7'd2, 7'd1}, {7'd3, 7'd2}, {7'd4, 7'd2}};

    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-length line: one pixel, latency 4.
    model_line(5, 5, 5, 5, n_model);
    chk("model_single_size", exp_q.size(), 1);
    start_line(5, 5, 5, 5, 4);
    finish_line(-1, -1, 1);

    model_line(0, 0, 4, 2, n_model);
    chk("model_42_n", n_model, 2);
    for (int i = 0; i < 5; i++) chk("model_42_pix", exp_q[i], lit42[i]);
    start_line(0, 0, 4, 2, 6);
    finish_line(-1, -1, 5);

    // Negative truncated slope plus 5-cycle backpressure mid-line.
    model_line(20, 0, 3, 0, n_model);
    chk("model_20_n", n_model, 5);
    chk("model_20_size", exp_q.size(), 33);
    chk("model_20_k31", exp_q[31], {7'd5, 7'd0});
    chk("model_20_last", exp_q[32], {7'd3, 7'd0});
    start_line(20, 0, 3, 0, 9);
    finish_line(10, -1, 33);

    // Start pulsed with new endpoints while busy must not disturb the line.
    model_line(10, 100, 90, 20, n_model);
    start_line(10, 100, 90, 20, 11);
    finish_line(-1, 5, 129);

    model_line(3, 9, 7, 2, n_model);
    start_line(3, 9, 7, 2, 7);
    finish_line(3, -1, 9);

    // Reset mid-line.
    model_line(0, 0, 100, 50, n_model);
    start_line(0, 0, 100, 50, 11);
    repeat (15) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 chk_outputs_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    act = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || done || pix_valid) act++;
    end
    chk("quiet_after_reset", act, 0);

    model_line(0, 0, 1, 0, n_model);
    chk("model_10_pix0", exp_q[0], {7'd0, 7'd0});
    chk("model_10_pix1", exp_q[1], {7'd1, 7'd0});
    start_line(0, 0, 1, 0, 4);
    finish_line(-1, -1, 2);

    model_line(0, 0, 127, 127, n_model);
    chk("model_127_size", exp_q.size(), 129);
    chk("model_127_last", exp_q[128], {7'd127, 7'd127});
    start_line(0, 0, 127, 127, 11);
    finish_line(-1, -1, 129);

    model_line(127, 0, 0, 127, n_model);
    start_line(127, 0, 0, 127, 11);
    finish_line(40, -1, 129);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
